// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the framed serial transmitter.
package parity_frame_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam int DEFAULT_DATA_W       = 4;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  // Total clock cycles one frame occupies the line (start + data + parity + stop).
  function automatic int frame_cycles(input int data_w, input int cpb, input int stop);
    return (2 + data_w + stop) * cpb;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Input-side handshake bundle: word and parity from the parity generator.
interface parity_frame_tx_if #(parameter int DATA_W = 4);
  logic [DATA_W-1:0] din;
  logic              parity_bit;
  logic              in_valid;
  logic              in_ready;

  modport master (output din, output parity_bit, output in_valid, input in_ready);
  modport slave  (input din, input parity_bit, input in_valid, output in_ready);
endinterface

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period down-counter: bit_tick marks the last cycle of each serial bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  // Held in clear while idle so the first bit of a frame gets a full period.
  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (clear || cnt == '0)  cnt <= CW'(CLKS_PER_BIT - 1);
    else                          cnt <= cnt - 1'b1;
  end

  assign bit_tick = !clear && (cnt == '0);
endmodule

// File: rtl/parity_frame_tx.sv
// Serialises word + parity as start, data LSB-first, parity, stop bit(s).
// Optional input parity checker: define PARITY_FRAME_TX_CHECK_EN.
module parity_frame_tx
  import parity_frame_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                rst,
  parity_frame_tx_if.slave    up,
  output logic                tx,
  output logic                busy,
  output logic                frame_done,
  output logic                parity_err
);
  localparam int IW = $clog2(DATA_W) + 1;

  state_e            state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic              par_q;
  logic [IW-1:0]     bit_idx;
  logic [0:0]        stop_idx;
  logic              rdy_q;
  logic              tick;
  logic              accept;
  logic              last_stop;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .bit_tick (tick)
  );

  assign up.in_ready = rdy_q & ~rst;
  assign accept      = up.in_valid & up.in_ready;
  assign shift_nxt   = shift_reg >> 1;
  assign last_stop   = (stop_idx == 1'(STOP_BITS - 1));
  assign frame_done  = !rst && (state == STOP) && last_stop && tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      rdy_q     <= 1'b1;
      shift_reg <= '0;
      par_q     <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          shift_reg <= up.din;
          par_q     <= up.parity_bit;
          state     <= START;
          tx        <= 1'b0;
          busy      <= 1'b1;
          rdy_q     <= 1'b0;
        end
        START: if (tick) begin
          state   <= DATA;
          tx      <= shift_reg[0];
          bit_idx <= '0;
        end
        DATA: if (tick) begin
          if (bit_idx == IW'(DATA_W - 1)) begin
            state <= PARITY;
            tx    <= par_q;
          end else begin
            shift_reg <= shift_nxt;
            tx        <= shift_nxt[0];
            bit_idx   <= bit_idx + 1'b1;
          end
        end
        PARITY: if (tick) begin
          state    <= STOP;
          tx       <= 1'b1;
          stop_idx <= '0;
        end
        STOP: if (tick) begin
          if (last_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            rdy_q <= 1'b1;
          end else begin
            stop_idx <= stop_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PARITY_FRAME_TX_CHECK_EN
  // Re-evaluated on every accept, so a matching word clears a previous error.
  logic perr_q;
  always_ff @(posedge clk) begin
    if (rst)         perr_q <= 1'b0;
    else if (accept) perr_q <= (^up.din) != up.parity_bit;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Downstream consumer of the even-parity generator.
- Accepts a DATA_W-bit word plus its parity_bit and serialises them onto a single line as a framed bit stream: start, data LSB-first, parity, stop.
- Valid/ready handshake on the input side; one-cycle frame_done pulse per completed frame.
- Sits between the parity generator and the off-block serial link.

Parameters:
- DATA_W, 4: data word width; matches the generator's din width.
- CLKS_PER_BIT, 4: clock cycles each serial bit is held; legal range ≥1.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  DATA_W  data word from the parity generator.
- parity_bit  input  1  even-parity bit from the generator, aligned with din.
- in_valid  input  1  din/parity_bit valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- tx  output  1  serial line; idles high.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.
- parity_err  output  1  parity mismatch flag (optional feature).

Behaviour:
- Reset values: tx=1, in_ready=1, busy=0, frame_done=0, parity_err=0, state=IDLE, counters=0.
- Accept rule: a transfer occurs when in_valid && in_ready at a rising edge. din and parity_bit are captured into a shift register and a parity latch.
- in_ready=1 only in IDLE and never while rst is high. Inputs are ignored when in_ready=0.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY after DATA_W bits.
  - PARITY → STOP after one bit.
  - STOP → IDLE after STOP_BITS bits.
- Outputs by state:
  - START: tx=0.
  - DATA: tx=shift_reg[0]; shift right once per bit period; LSB first.
  - PARITY: tx=latched parity_bit.
  - STOP and IDLE: tx=1.
- Bit timer: counts 0..CLKS_PER_BIT-1. The bit advances when timer==CLKS_PER_BIT-1. A data-bit index counter counts 0..DATA_W-1, sized $clog2(DATA_W)+1 bits.
- Latency: tx goes low on the first cycle after the accept edge.
- Frame length: (2+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles. With defaults this is 28 cycles.
- frame_done: asserts on the last cycle of the final stop bit, concurrent with tx=1.
- Next frame: the block is in IDLE with in_ready=1 on the following cycle. The minimum gap between frames is one idle cycle at tx=1.
- busy=1 in every non-IDLE state.
- in_valid held high continuously: frames go back-to-back, each separated by exactly one IDLE cycle.
- Reset mid-frame: on the next edge the block returns to IDLE, tx=1, and the partial frame is discarded; no frame_done is issued.
- CLKS_PER_BIT=1: every bit lasts one cycle; the timer is constant 0.

Optional Feature:
- Macro: PARITY_FRAME_TX_CHECK_EN.
- When defined:
  - On accept, the block recomputes even parity (XOR reduce of din) and compares it with parity_bit.
  - parity_err is sticky: it sets on mismatch and clears on rst or on the next accepted word whose parity matches.
  - The transmitted parity bit is always the received parity_bit; the frame is never altered.
- When undefined: no checker logic is built and parity_err is tied to 0.

Decomposition:
- Shared package parity_frame_pkg:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants: DEFAULT_DATA_W, DEFAULT_CLKS_PER_BIT.
  - Function frame_cycles(data_w, cpb, stop).
- One sub-module, bit_timer: a parameterised CLKS_PER_BIT down-counter with a bit_tick output and a synchronous clear.

Test Plan:
- Basic frame (defaults): din=4'b0011, parity_bit=0, one-cycle in_valid → tx sequence 0,1,1,0,0,0,1, each held 4 cycles; frame_done at cycle 28 after accept; in_ready back high at cycle 29.
- Odd data: din=4'b0111, parity_bit=1 → data bits 1,1,1,0, then parity bit 1; busy high for exactly 28 cycles.
- Back-to-back: in_valid held high with din=4'b1010 then 4'b1001 → two frames separated by exactly 1 cycle of tx=1; second start bit at cycle 30 after the first accept.
- Backpressure: pulse in_valid with din=4'b1111 at cycle 10 of a frame → word ignored; tx output matches the first frame only.
- Reset mid-frame: assert rst during the DATA state for one cycle → next edge tx=1, in_ready=1, busy=0, no frame_done.
- With PARITY_FRAME_TX_CHECK_EN:
  - din=4'b0001 with parity_bit=0 → parity_err=1 after accept; the frame still transmits parity 0.
  - Next word din=4'b0001 with parity_bit=1 → parity_err clears.
